flac_frame_scheduler: RTL
=========================

Name: flac_frame_scheduler

Overview:
- Front-end controller for the fLaC encoder pipeline.
- Accepts a raw sample stream with a valid/ready handshake and cuts it into frames of FRAME_LEN samples.
- Sequences the output-RAM clear period before streaming, and limits the number of frames in flight in the pipeline using the pipeline's frame-done pulse.
- Feeds the encoder's iSample/iValid and drives its output-stage clear input.

Parameters:
- FRAME_LEN, 4096: samples per frame (power of two not required; must be at least 2).
- CLEAR_CYCLES, 4096: cycles oClear is held high after start.
- MAX_INFLIGHT, 2: maximum frames issued but not yet reported done (1..7).
- FNUM_W, 16: frame-number counter width.

Ports:
- iClock  in  1  system clock, rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iEnable  in  1  global enable. When low, all state holds, oValid=0 and oSReady=0.
- iStart  in  1  one-cycle pulse; starts a session from IDLE.
- iStop  in  1  one-cycle pulse; finish the current frame, drain, then return to IDLE.
- iSample  in  16  signed input sample.
- iSValid  in  1  input sample valid.
- oSReady  out  1  scheduler can accept a sample this cycle.
- oSample  out  16  signed sample to the encoder.
- oValid  out  1  sample valid to the encoder.
- oClear  out  1  output-stage RAM clear.
- oFrameStart  out  1  pulse coincident with the first sample of each frame.
- oFrameNumber  out  FNUM_W  number of the frame currently being issued.
- iFrameDone  in  1  one-cycle pulse from the encoder when a frame is fully written out.
- oInFlight  out  3  frames issued and not yet done.
- oBusy  out  1  high in any state other than IDLE.
- oError  out  1  sticky; set when iFrameDone arrives while in-flight count is 0.

Behaviour:
- Reset (iReset_n=0, asynchronous):
  - State goes to IDLE.
  - Every output is 0: oSReady, oValid, oClear, oFrameStart, oBusy, oError, oSample, oFrameNumber, oInFlight.
  - All counters are 0.
  - Reset asserted mid-frame aborts immediately; no partial-frame completion.
- Handshake:
  - A sample transfers when iSValid && oSReady && iEnable are all high.
  - oSample/oValid are registered, giving one cycle of latency: a transfer in cycle N produces oValid=1 with that sample in cycle N+1.
  - oValid=0 in every cycle without a transfer in the previous cycle.
  - oSReady is combinational from state and counters only. It never depends on iSValid.
- IDLE:
  - oSReady=0, oBusy=0.
  - iStart moves to CLEAR, loads the clear counter with 0 and sets oClear=1 in the next cycle.
  - iStop in IDLE is ignored.
- CLEAR:
  - oClear=1 for exactly CLEAR_CYCLES cycles, then STREAM with oClear=0.
  - iStop during CLEAR is latched and honoured at the first frame boundary.
- STREAM:
  - oSReady = (inflight < MAX_INFLIGHT) || (sample count != 0). Once a frame has begun, it is never stalled by the in-flight limit.
  - The sample counter increments per transfer.
  - At the transfer with count==0: oFrameStart pulses alongside that sample's oValid cycle, and the in-flight count increments.
  - At the transfer with count==FRAME_LEN-1: the counter wraps to 0 and oFrameNumber increments, wrapping modulo 2^FNUM_W. The new number is visible from the next frame's first sample.
  - If a stop is pending, the last-sample transfer moves the state to DRAIN.
  - iStop arriving while count==0 (between frames) goes straight to DRAIN without issuing a frame.
- DRAIN:
  - oSReady=0.
  - When the in-flight count reaches 0, go to IDLE.
  - oFrameNumber is preserved across sessions; only reset clears it.
- In-flight counter:
  - Increment at frame start; decrement on iFrameDone.
  - If both happen in the same cycle, the count is unchanged.
  - iFrameDone with a count of 0 does not decrement, and sets oError. oError is cleared only by reset.
- iStart outside IDLE is ignored.
- iEnable low:
  - Freezes counters and state. The clear counter also holds, with oClear held at its current value.
  - iFrameDone is still counted, because the encoder pipeline may be free-running.
  - iStart/iStop pulses while iEnable is low are still latched.

Test Plan:
- Reset, then iStart, FRAME_LEN=8, CLEAR_CYCLES=4 → oClear high exactly 4 cycles; oSReady rises the cycle after oClear falls.
- Continuous iSValid with samples 1..16 → oValid one cycle later with the same values; oFrameStart on samples 1 and 9; oFrameNumber 0 then 1; oInFlight 1 then 2.
- MAX_INFLIGHT=2, no iFrameDone → after 16 samples oSReady=0. Pulse iFrameDone → oSReady=1 next cycle, oInFlight=1.
- iStop at sample 3 of a frame → samples 4..8 still accepted; DRAIN; two iFrameDone pulses → IDLE, oBusy=0.
- iFrameDone coincident with a frame start → oInFlight unchanged. iFrameDone at oInFlight=0 → oError=1 and sticky.
- iReset_n low mid-frame asynchronously (between clock edges) → all outputs 0 immediately. After release, iStart restarts with a CLEAR phase and oFrameNumber=0.

Source files
------------

// File: rtl/flac_frame_scheduler.sv
// Front-end scheduler for the fLaC encoder: it sequences the output-RAM clear,
// cuts the sample stream into frames, and limits how many frames are in flight.
module flac_frame_scheduler #(
  parameter int FRAME_LEN    = 4096,
  parameter int CLEAR_CYCLES = 4096,
  parameter int MAX_INFLIGHT = 2,
  parameter int FNUM_W       = 16
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iEnable,
  input  logic              iStart,
  input  logic              iStop,
  input  logic [15:0]       iSample,
  input  logic              iSValid,
  output logic              oSReady,
  output logic [15:0]       oSample,
  output logic              oValid,
  output logic              oClear,
  output logic              oFrameStart,
  output logic [FNUM_W-1:0] oFrameNumber,
  input  logic              iFrameDone,
  output logic [2:0]        oInFlight,
  output logic              oBusy,
  output logic              oError
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;

  localparam logic [CW-1:0] LAST_SAMP = CW'(FRAME_LEN - 1);
  localparam logic [KW-1:0] LAST_CLR  = KW'(CLEAR_CYCLES - 1);
  localparam logic [2:0]    MAX_IF    = 3'(MAX_INFLIGHT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]        state;
  logic [KW-1:0]     clr_cnt;
  logic [CW-1:0]     samp_cnt;
  logic [FNUM_W-1:0] fnum_cnt;
  logic [FNUM_W-1:0] fnum_out;
  logic [2:0]        inflight;
  logic              err_r;
  logic              clear_r;
  logic              start_pend;
  logic              stop_pend;
  logic              valid_r;
  logic              fstart_r;
  logic [15:0]       sample_r;

  logic sready;
  logic xfer;
  logic frame_open;
  logic first_xfer;
  logic last_xfer;
  logic stop_req;
  logic done_ok;

  assign frame_open = (samp_cnt != '0);
  assign stop_req   = stop_pend | iStop;

  // A pending stop between frames closes the door so no new frame is opened.
  always_comb begin
    sready = 1'b0;
    if (iEnable && (state == ST_STREAM))
      sready = frame_open || ((inflight < MAX_IF) && !stop_pend);
  end

  assign xfer       = iEnable & iSValid & sready;
  assign first_xfer = xfer & ~frame_open;
  assign last_xfer  = xfer & (samp_cnt == LAST_SAMP);
  assign done_ok    = iFrameDone & (inflight != '0);

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      samp_cnt   <= '0;
      fnum_cnt   <= '0;
      fnum_out   <= '0;
      inflight   <= '0;
      err_r      <= 1'b0;
      clear_r    <= 1'b0;
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
      valid_r    <= 1'b0;
      fstart_r   <= 1'b0;
      sample_r   <= '0;
    end else begin
      // Frame-done pulses are counted regardless of iEnable.
      case ({first_xfer, done_ok})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
      if (iFrameDone && (inflight == '0))
        err_r <= 1'b1;

      valid_r  <= xfer;
      fstart_r <= first_xfer;
      if (xfer)
        sample_r <= iSample;
      if (first_xfer)
        fnum_out <= fnum_cnt;

      // Pulses are latched even while disabled; transitions below consume them.
      if (iStart && (state == ST_IDLE))
        start_pend <= 1'b1;
      if (iStop && ((state == ST_CLEAR) || (state == ST_STREAM)))
        stop_pend <= 1'b1;

      if (iEnable) begin
        case (state)
          ST_IDLE: begin
            if (iStart || start_pend) begin
              state      <= ST_CLEAR;
              clr_cnt    <= '0;
              clear_r    <= 1'b1;
              start_pend <= 1'b0;
              stop_pend  <= 1'b0;
            end
          end
          ST_CLEAR: begin
            if (clr_cnt == LAST_CLR) begin
              state   <= ST_STREAM;
              clear_r <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          ST_STREAM: begin
            if (xfer) begin
              if (last_xfer) begin
                samp_cnt <= '0;
                fnum_cnt <= fnum_cnt + 1'b1;
                if (stop_req) begin
                  state     <= ST_DRAIN;
                  stop_pend <= 1'b0;
                end
              end else begin
                samp_cnt <= samp_cnt + 1'b1;
              end
            end else if (!frame_open && stop_req) begin
              state     <= ST_DRAIN;
              stop_pend <= 1'b0;
            end
          end
          default: begin
            if (inflight == '0)
              state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign oSReady      = sready;
  assign oSample      = sample_r;
  assign oValid       = valid_r & iEnable;
  assign oFrameStart  = fstart_r & iEnable;
  assign oClear       = clear_r;
  assign oFrameNumber = fnum_out;
  assign oInFlight    = inflight;
  assign oBusy        = (state != ST_IDLE);
  assign oError       = err_r;

endmodule
